// File: rtl/dram_resp_pkg.sv
// Shared constants and types for the DRAM responder model.
// The optional ack-stall LFSR is enabled by defining DRAM_RESP_MODEL_STALL_EN.
package dram_resp_pkg;

  localparam int DEF_DW       = 64;
  localparam int DEF_AW       = 12;
  localparam int DEF_LAT      = 8;
  localparam int DEF_OUTSTAND = 4;
  localparam int MASK_W       = DEF_DW / 8;
  localparam int DEF_CNT_W    = $clog2(DEF_LAT + 1);

  typedef struct packed {
    logic [DEF_DW-1:0]    data;
    logic [DEF_CNT_W-1:0] cnt;
  } rd_entry_t;

  // Fibonacci taps 16,14,13,11 expressed as a mask on state bits 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/dram_resp_queue.sv
// In-order read return FIFO: each entry carries its data and a latency
// countdown; the head may leave only once its countdown has reached zero.
module dram_resp_queue #(
  parameter int DW       = 64,
  parameter int LAT      = 8,
  parameter int OUTSTAND = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic          head_valid_o,
  output logic          head_ready_o,
  output logic [DW-1:0] head_data_o,
  output logic          full_o
);

  localparam int CNT_W = $clog2(LAT + 1);
  localparam int PTR_W = (OUTSTAND > 1) ? $clog2(OUTSTAND) : 1;
  localparam int OCC_W = $clog2(OUTSTAND + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTAND - 1);
  localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(OUTSTAND);

  typedef struct packed {
    logic [DW-1:0]    data;
    logic [CNT_W-1:0] cnt;
  } entry_t;

  entry_t [OUTSTAND-1:0] ent_q, ent_d;
  logic   [OUTSTAND-1:0] vld_q, vld_d;
  logic   [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic   [OCC_W-1:0]    occ_q, occ_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign head_valid_o = vld_q[rd_ptr_q];
  assign head_ready_o = (ent_q[rd_ptr_q].cnt == '0);
  assign head_data_o  = ent_q[rd_ptr_q].data;
  assign full_o       = (occ_q == OCC_MAX);

  // Push after pop so a full queue can refill the slot it frees in the same cycle
  always_comb begin
    ent_d    = ent_q;
    vld_d    = vld_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    for (int i = 0; i < OUTSTAND; i++) begin
      if (vld_q[i] && (ent_q[i].cnt != '0)) begin
        ent_d[i].cnt = ent_q[i].cnt - CNT_W'(1);
      end
    end
    if (pop_i) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = ptr_inc(rd_ptr_q);
    end
    if (push_i) begin
      ent_d[wr_ptr_q].data = push_data_i;
      ent_d[wr_ptr_q].cnt  = CNT_INIT;
      vld_d[wr_ptr_q]      = 1'b1;
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    occ_d = occ_q + OCC_W'(push_i) - OCC_W'(pop_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ent_q    <= '0;
      vld_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      ent_q    <= ent_d;
      vld_q    <= vld_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule

// File: rtl/dram_resp_model.sv
// DRAM-side responder: byte-masked memory, fixed-latency in-order reads with a
// bounded number outstanding. Define DRAM_RESP_MODEL_STALL_EN for LFSR ack stalls.
module dram_resp_model
  import dram_resp_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int AW       = DEF_AW,
  parameter int LAT      = DEF_LAT,
  parameter int OUTSTAND = DEF_OUTSTAND
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            ra_rdy,
  output logic            ra_ack,
  input  logic [AW-1:0]   ra_addr,
  output logic            rd_rdy,
  input  logic            rd_ack,
  output logic [DW-1:0]   rd_data,
  input  logic            w_rdy,
  output logic            w_ack,
  input  logic [AW-1:0]   w_addr,
  input  logic [DW-1:0]   w_data,
  input  logic [DW/8-1:0] w_mask
);

  logic [DW-1:0] mem [2**AW];

  logic head_valid, head_ready, full;
  logic pop, ra_ok, w_ok;

  assign rd_rdy = head_valid && head_ready;
  assign pop    = rd_rdy && rd_ack;

`ifdef DRAM_RESP_MODEL_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = lfsr_next(lfsr_q);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign ra_ok = ~lfsr_q[0];
  assign w_ok  = ~lfsr_q[1];
`else
  assign ra_ok = 1'b1;
  assign w_ok  = 1'b1;
`endif

  assign ra_ack = ra_rdy && ra_ok && (!full || pop);
  assign w_ack  = w_rdy && w_ok;

  // Read samples mem combinationally, so a same-cycle write is not yet visible
  dram_resp_queue #(
    .DW       (DW),
    .LAT      (LAT),
    .OUTSTAND (OUTSTAND)
  ) u_queue (
    .clk_i        (i_clk),
    .rst_ni       (i_rst),
    .push_i       (ra_ack),
    .push_data_i  (mem[ra_addr]),
    .pop_i        (pop),
    .head_valid_o (head_valid),
    .head_ready_o (head_ready),
    .head_data_o  (rd_data),
    .full_o       (full)
  );

  always_ff @(posedge i_clk) begin
    if (w_ack) begin
      for (int b = 0; b < DW / 8; b++) begin
        if (w_mask[b]) mem[w_addr][b*8 +: 8] <= w_data[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dram_resp_model.sv
// Scoreboard bench for dram_resp_model: a reference memory plus an ordered
// queue of expected read returns, checked every cycle by a negedge monitor.
module tb_dram_resp_model;

  localparam int DW       = 64;
  localparam int AW       = 12;
  localparam int LAT      = 8;
  localparam int OUTSTAND = 4;
  localparam int MW       = DW / 8;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          ra_rdy = 1'b0;
  logic          ra_ack;
  logic [AW-1:0] ra_addr = '0;
  logic          rd_rdy;
  logic          rd_ack = 1'b0;
  logic [DW-1:0] rd_data;
  logic          w_rdy = 1'b0;
  logic          w_ack;
  logic [AW-1:0] w_addr = '0;
  logic [DW-1:0] w_data = '0;
  logic [MW-1:0] w_mask = '0;

  typedef struct {
    logic [DW-1:0] data;
    int            t;
  } exp_t;

  exp_t          expQ[$];
  logic [DW-1:0] refMem [2**AW];
  int            compared   = 0;
  int            mismatched = 0;
  int            cyc        = 0;
  int            stallSeen  = 0;
  bit            stopRand   = 0;

  dram_resp_model #(
    .DW(DW), .AW(AW), .LAT(LAT), .OUTSTAND(OUTSTAND)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .ra_rdy  (ra_rdy),
    .ra_ack  (ra_ack),
    .ra_addr (ra_addr),
    .rd_rdy  (rd_rdy),
    .rd_ack  (rd_ack),
    .rd_data (rd_data),
    .w_rdy   (w_rdy),
    .w_ack   (w_ack),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .w_mask  (w_mask)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: transfers are decided by the values settled at the negedge before the edge
  always @(negedge i_clk) begin
    logic          expRdy, rdXfer, allowRa;
    logic [DW-1:0] bitMask;
    cyc++;
    if (!i_rst) begin
      checkOutput("rstRdRdy", 64'(rd_rdy), 64'd0);
      checkOutput("rstRaAck", 64'(ra_ack), 64'd0);
      checkOutput("rstWAck", 64'(w_ack), 64'd0);
      checkOutput("rstRdData", rd_data, 64'd0);
      expQ.delete();
    end else begin
      expRdy = (expQ.size() > 0) && (cyc >= expQ[0].t + LAT);
      checkOutput("rdRdy", 64'(rd_rdy), 64'(expRdy));
      if (rd_rdy && expQ.size() > 0) checkOutput("rdData", rd_data, expQ[0].data);
      rdXfer  = rd_rdy && rd_ack;
      allowRa = ra_rdy && ((expQ.size() < OUTSTAND) || rdXfer);
      if (ra_rdy && !ra_ack && expQ.size() < OUTSTAND) stallSeen++;
`ifdef DRAM_RESP_MODEL_STALL_EN
      checkOutput("raAckIllegal", 64'(ra_ack && !allowRa), 64'd0);
      checkOutput("wAckIllegal", 64'(w_ack && !w_rdy), 64'd0);
`else
      checkOutput("raAck", 64'(ra_ack), 64'(allowRa));
      checkOutput("wAck", 64'(w_ack), 64'(w_rdy));
`endif
      if (rdXfer && expQ.size() > 0) void'(expQ.pop_front());
      if (ra_rdy && ra_ack) expQ.push_back('{data: refMem[ra_addr], t: cyc});
      if (w_rdy && w_ack) begin
        bitMask = '0;
        for (int b = 0; b < MW; b++) if (w_mask[b]) bitMask |= (64'hFF << (8 * b));
        refMem[w_addr] = (refMem[w_addr] & ~bitMask) | (w_data & bitMask);
      end
    end
  end

  // Holds each requested transfer until it has been accepted, then drops it
  task automatic applyStimulus(input bit doR, input logic [AW-1:0] rAddr,
                               input bit doW, input logic [AW-1:0] wAddr,
                               input logic [DW-1:0] wData, input logic [MW-1:0] wMask);
    int budget;
    bit rAcc, wAcc;
    budget  = 200;
    ra_rdy  = doR;
    ra_addr = rAddr;
    w_rdy   = doW;
    w_addr  = wAddr;
    w_data  = wData;
    w_mask  = wMask;
    while ((ra_rdy || w_rdy) && budget > 0) begin
      @(negedge i_clk);
      rAcc = ra_rdy && ra_ack;
      wAcc = w_rdy && w_ack;
      @(posedge i_clk);
      #1;
      if (rAcc) ra_rdy = 1'b0;
      if (wAcc) w_rdy = 1'b0;
      budget--;
    end
    checkOutput("reqAccepted", 64'({ra_rdy, w_rdy}), 64'd0);
    ra_rdy = 1'b0;
    w_rdy  = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic waitDrain();
    int budget;
    budget = 500;
    rd_ack = 1'b1;
    while (expQ.size() > 0 && budget > 0) begin
      @(posedge i_clk);
      budget--;
    end
    #1;
    checkOutput("drainPending", 64'(expQ.size()), 64'd0);
  endtask

  initial begin
    #1 i_rst = 1'b0;
    idleCycles(3);
    i_rst = 1'b1;
    idleCycles(1);

    for (int a = 0; a < 64; a++)
      applyStimulus(0, '0, 1, 12'(a), {$urandom, $urandom}, 8'hFF);

    // Single read latency with rd_ack held high
    rd_ack = 1'b1;
    applyStimulus(0, '0, 1, 12'h010, 64'h1122334455667788, 8'hFF);
    applyStimulus(1, 12'h010, 0, '0, '0, '0);
    waitDrain();

    // Partial byte-mask write
    applyStimulus(0, '0, 1, 12'h020, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    applyStimulus(0, '0, 1, 12'h020, 64'h0, 8'h0F);
    applyStimulus(1, 12'h020, 0, '0, '0, '0);
    waitDrain();

    // Six reads against a four-deep queue with the return path stalled
    rd_ack = 1'b0;
    fork
      begin
        for (int a = 0; a < 6; a++) applyStimulus(1, 12'(a), 0, '0, '0, '0);
      end
      begin
        idleCycles(LAT + 6);
        rd_ack = 1'b1;
      end
    join
    waitDrain();

    // Same-cycle read and write to one address, then a follow-up read
    applyStimulus(0, '0, 1, 12'h030, 64'hBBBB_0000_BBBB_0000, 8'hFF);
    applyStimulus(1, 12'h030, 1, 12'h030, 64'hAAAA_5555_AAAA_5555, 8'hFF);
    applyStimulus(1, 12'h030, 0, '0, '0, '0);
    waitDrain();

    // Head held while rd_ack is low
    rd_ack = 1'b0;
    applyStimulus(1, 12'h011, 0, '0, '0, '0);
    idleCycles(LAT + 3);
    waitDrain();

    // Reset with reads in flight
    rd_ack = 1'b0;
    for (int a = 0; a < 3; a++) applyStimulus(1, 12'(a + 8), 0, '0, '0, '0);
    i_rst = 1'b0;
    idleCycles(2);
    i_rst  = 1'b1;
    rd_ack = 1'b1;
    idleCycles(20);

    // Random mixed traffic with a randomly stalling consumer
    fork
      begin
        int kind;
        for (int n = 0; n < 1000; n++) begin
          kind = int'($urandom_range(0, 2));
          applyStimulus(kind != 1, 12'($urandom_range(0, 63)), kind != 0,
                        12'($urandom_range(0, 63)), {$urandom, $urandom}, 8'($urandom));
        end
        stopRand = 1;
      end
      begin
        while (!stopRand) begin
          @(posedge i_clk);
          #1;
          rd_ack = ($urandom_range(0, 3) != 0);
        end
      end
    join
    waitDrain();

`ifdef DRAM_RESP_MODEL_STALL_EN
    checkOutput("stallObserved", 64'(stallSeen > 0), 64'd1);
`else
    checkOutput("noSpuriousStall", 64'(stallSeen), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dram_resp_model.md
Name: dram_resp_model

Overview:
- Parametrised DRAM responder for the DRAM side of Top: read-address, read-data and write channels, all rdy/ack.
- Replaces ad-hoc bench logic such as `ra_ack = ra_canack && ra_rdy` with a real memory and a configurable fixed read latency.
- Bounded outstanding reads with in-order return, and per-byte write mask.
- Synthesisable-style RTL, so it can also sit behind gate-level wrappers.

Parameters:
- DW, 64, data width in bits; must be a multiple of 8.
- AW, 12, word address width; memory depth is 2**AW words.
- LAT, 8, read latency in cycles from ra acceptance to earliest rd_rdy; must be ≥1.
- OUTSTAND, 4, maximum reads accepted but not yet acked on rd; must be ≥1.

Ports:
- i_clk in 1: clock.
- i_rst in 1: asynchronous active-low reset.
- ra_rdy in 1: read request valid.
- ra_ack out 1: read request accepted.
- ra_addr in AW: read word address.
- rd_rdy out 1: read data valid.
- rd_ack in 1: read data consumed.
- rd_data out DW: read data.
- w_rdy in 1: write request valid.
- w_ack out 1: write accepted.
- w_addr in AW: write word address.
- w_data in DW: write data.
- w_mask in DW/8: byte enables, 1 = write that byte.

Behaviour:
- Handshake: a transfer occurs in a cycle where rdy && ack. A source holds rdy and payload stable until ack. ack is combinational from rdy and registered state only.
- Reset (i_rst=0, async): ra_ack=0, w_ack=0, rd_rdy=0, rd_data=0. Queue emptied, occupancy=0. Memory contents not cleared.
- Reset mid-operation discards all in-flight reads. No rd is issued for them after reset is released.
- Read queue: FIFO of OUTSTAND entries, each holding {data[DW], cnt[$clog2(LAT+1)]}.
- On ra transfer, mem[ra_addr] is sampled that cycle and pushed at the tail with cnt=LAT-1.
- Every cycle, each valid entry with cnt>0 decrements.
- rd_rdy = head valid && head.cnt==0. rd_data = head.data; it is a register and stays stable while rd_rdy && !rd_ack.
- A read accepted at cycle T gives rd_rdy no earlier than cycle T+LAT.
- Pop on rd transfer.
- ra_ack = ra_rdy && (occupancy<OUTSTAND || rd transfer this cycle); push and pop in the same cycle is allowed when full.
- occupancy next = occupancy + push − pop, never exceeding OUTSTAND.
- Write: w_ack = w_rdy. Bytes with mask bit 1 are written at the clock edge of the transfer; mask 0 leaves the byte unchanged.
- Read and write to the same address in the same cycle: the read samples the OLD data.
- A write accepted in cycle T is visible to reads accepted in cycle T+1 or later.
- Addresses index directly; no range check is needed.
- Ordering: rd returns strictly in ra acceptance order.
- rd stall (rd_ack=0) backs up the queue. Later entries keep counting down and are returned back-to-back once the head pops.

Optional Feature:
- Macro: DRAM_RESP_MODEL_STALL_EN.
- With it: a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 on reset) advances every cycle.
  - When lfsr[0]==1, ra_ack is forced 0.
  - When lfsr[1]==1, w_ack is forced 0.
  - The ack formula otherwise stays as above.
- Without it: no LFSR logic; acks as specified above.

Decomposition:
- Shared package dram_resp_pkg:
  - localparam MASK_W = DW/8.
  - typedef of the queue entry struct {data, cnt}.
  - LFSR seed and tap constants.
- One natural sub-module: dram_resp_queue.
  - Holds the OUTSTAND-deep FIFO with countdown and push/pop/occupancy logic.
  - Outputs head_valid, head_ready, head_data and full.
- Top level holds the memory array, write masking and ack logic.

Test Plan:
- Reset, then write addr 0x010 data 64'h1122334455667788 mask 8'hFF. Read 0x010 with rd_ack=1 constantly, LAT=8 → rd_rdy rises exactly 8 cycles after ra transfer, with that data.
- Write 0x020 = 64'hFFFF_FFFF_FFFF_FFFF, then write 0x020 data 0 mask 8'h0F → a later read returns 64'hFFFF_FFFF_0000_0000.
- OUTSTAND=4, rd_ack=0, issue 6 reads to addrs 0..5:
  - ra_ack is 0 after 4 accepts.
  - Raise rd_ack → data for addr 0..5 is returned in order.
  - The 5th read is accepted in the same cycle as the first pop.
- Same-cycle write 0x030=A (old value B) and read 0x030 → read returns B. A read of 0x030 in the next cycle returns A.
- Hold rd_ack=0 for 3 cycles while rd_rdy=1 → rd_data is stable over all 3 cycles.
- Assert i_rst=0 with 3 reads in flight, release → rd_rdy stays 0 for 20 cycles.
- With DRAM_RESP_MODEL_STALL_EN: 1000 random reads and writes checked against a scoreboard → no data mismatch and ra_ack observed 0 at least once while the queue is not full.
